// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with a fixed access latency, answering
// one word load or store at a time over valid/ready request and response handshakes.
//
// Parameters:
//   DEPTH   - number of 32-bit words (power of 2, >= 2)
//   LATENCY - edges from request acceptance to o_resp_valid (>= 1)
//
// Ports:
//   i_clk          clock, rising-edge
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    request present
//   o_req_ready    responder idle and able to accept
//   i_req_we       1 = store, 0 = load
//   i_req_addr     byte address, bits [1:0] ignored
//   i_req_wdata    store data
//   o_resp_valid   response available, held until i_resp_ready
//   i_resp_ready   initiator takes the response
//   o_resp_rdata   load data, 0 for stores and errored accesses
//   o_resp_err     out-of-range address (only with bounds checking)
//
// Build option:
//   DMEM_BOUNDS_CHECK_EN - when defined, word addresses >= DEPTH raise o_resp_err,
//   read as 0 and never write; when undefined they alias modulo DEPTH.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [31:0]     r_wdata;
    logic [AW-1:0]   r_idx;
    logic            r_oob;
    logic            r_resp_valid;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    logic            w_oob_in;
    logic            w_we;
    logic [31:0]     w_wdata;
    logic [AW-1:0]   w_idx;
    logic            w_oob;
    logic            w_enter_resp;
    logic            w_unused;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_oob_in = {2'b00, i_req_addr[31:2]} >= 32'(DEPTH);
`else
    assign w_oob_in = 1'b0;
`endif

    // Low address bits are always ignored; high bits only feed the bounds check.
    assign w_unused = &{1'b0, i_req_addr[1:0], i_req_addr[31:AW+2]};

    // With LATENCY == 1 the array is accessed on the accepting edge itself,
    // before the captured registers hold the request, so take it from the inputs.
    assign w_we    = (r_state == IDLE) ? i_req_we          : r_we;
    assign w_wdata = (r_state == IDLE) ? i_req_wdata       : r_wdata;
    assign w_idx   = (r_state == IDLE) ? i_req_addr[AW+1:2] : r_idx;
    assign w_oob   = (r_state == IDLE) ? w_oob_in          : r_oob;

    assign w_enter_resp = (r_state == IDLE) ? (i_req_valid && (LATENCY == 1))
                                            : ((r_state == WAIT) && (r_cnt == '0));

    assign o_req_ready  = (r_state == IDLE);
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;

    // Array has no reset; a store only lands on the edge that enters RESP, so
    // a reset during WAIT discards it.
    always_ff @(posedge i_clk) begin
        if (w_enter_resp && w_we && !w_oob)
            r_mem[w_idx] <= w_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_idx        <= '0;
            r_oob        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_we    <= i_req_we;
                        r_wdata <= i_req_wdata;
                        r_idx   <= i_req_addr[AW+1:2];
                        r_oob   <= w_oob_in;
                        r_cnt   <= CW'(LATENCY - 1);
                        r_state <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0)
                        r_state <= RESP;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                RESP: begin
                    if (i_resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_rdata      <= (w_we || w_oob) ? 32'd0 : r_mem[w_idx];
                r_err        <= w_oob;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_we(a_req_we),
        .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata),
        .o_resp_valid(a_resp_valid), .i_resp_ready(a_resp_ready),
        .o_resp_rdata(a_resp_rdata), .o_resp_err(a_resp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_we(b_req_we),
        .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata),
        .o_resp_valid(b_resp_valid), .i_resp_ready(b_resp_ready),
        .o_resp_rdata(b_resp_rdata), .o_resp_err(b_resp_err)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_oob(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
        return (a >> 2) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // One transaction on u_dut with `stall` cycles of response backpressure,
    // during which a bogus request is held on the request port.
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        bit          oob;
        int          idx;
        bit          chk_data;
        logic [31:0] exp;
        oob = m_oob(addr);
        idx = m_idx(addr);
        if (we) begin
            exp = 32'd0;
            chk_data = 1'b1;
            if (!oob) begin
                ref_mem[idx]   = wdata;
                ref_known[idx] = 1'b1;
            end
        end else begin
            exp = oob ? 32'd0 : ref_mem[idx];
            chk_data = oob || ref_known[idx];
        end
        check("req_ready_idle", 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        a_req_we    = 1'($urandom);
        a_req_addr  = $urandom;
        a_req_wdata = $urandom;
        repeat (LAT) begin
            check("wait_resp_valid", 32'(a_resp_valid), 32'd0);
            check("wait_req_ready", 32'(a_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("resp_valid", 32'(a_resp_valid), 32'd1);
        if (chk_data) check("resp_rdata", a_resp_rdata, exp);
        check("resp_err", 32'(a_resp_err), 32'(oob));
        for (int s = 0; s < stall; s++) begin
            a_req_valid = 1'b1;
            a_req_we    = 1'b1;
            a_req_addr  = addr;
            a_req_wdata = ~wdata;
            @(posedge clk); #1;
            check("bp_resp_valid", 32'(a_resp_valid), 32'd1);
            check("bp_req_ready", 32'(a_req_ready), 32'd0);
            if (chk_data) check("bp_resp_rdata", a_resp_rdata, exp);
            check("bp_resp_err", 32'(a_resp_err), 32'(oob));
        end
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        a_req_valid  = 1'b0;
        check("done_resp_valid", 32'(a_resp_valid), 32'd0);
        check("done_req_ready", 32'(a_req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        logic [31:0] b_data [4];
        logic [31:0] b_exp;
        int          n_resp;
        rst_n = 1'b0;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        check("rst_resp_rdata", a_resp_rdata, 32'd0);
        check("rst_resp_err", 32'(a_resp_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;

        txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(1'b0, 32'h10, 32'h0, 0);
        txn(1'b0, 32'h10, 32'h0, 5);
        txn(1'b1, 32'h10, 32'h12345678, 0);
        txn(1'b0, 32'h13, 32'h0, 2);
        txn(1'b1, 32'h0, 32'h11112222, 0);
        txn(1'b1, 32'h1000, 32'hCAFEF00D, 1);
        txn(1'b0, 32'h0, 32'h0, 0);
        txn(1'b0, 32'h1000, 32'h0, 0);

        // Reset while a store sits in WAIT: the store must never land.
        txn(1'b1, 32'h20, 32'h1, 0);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check("mid_wait_req_ready", 32'(a_req_ready), 32'd0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", 32'(a_resp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        check("mid_rst_hold_valid", 32'(a_resp_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("post_rst_req_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        txn(1'b0, 32'h20, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] addr;
            addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 3) == 0) addr = addr + 32'(DEPTH * 4 * $urandom_range(1, 3));
            txn(1'($urandom), addr, $urandom, $urandom_range(0, 3));
        end

        // LATENCY=1 instance: request and response ready held high, alternating store/load.
        n_resp = 0;
        b_resp_ready = 1'b1;
        b_req_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_req_we    = (i % 2 == 0);
            b_req_addr  = 32'h40 + 32'((i / 2) * 4);
            b_req_wdata = $urandom;
            if (b_req_we) b_data[i / 2] = b_req_wdata;
            b_exp = b_req_we ? 32'd0 : b_data[i / 2];
            @(posedge clk); #1;
            if (b_resp_valid === 1'b1) n_resp++;
            check("l1_resp_valid", 32'(b_resp_valid), 32'd1);
            check("l1_req_ready_busy", 32'(b_req_ready), 32'd0);
            check("l1_resp_rdata", b_resp_rdata, b_exp);
            check("l1_resp_err", 32'(b_resp_err), 32'd0);
            if (i == 7) b_req_valid = 1'b0;
            @(posedge clk); #1;
            check("l1_resp_drop", 32'(b_resp_valid), 32'd0);
            check("l1_req_ready_idle", 32'(b_req_ready), 32'd1);
        end
        @(posedge clk); #1;
        if (b_resp_valid === 1'b1) n_resp++;
        check("l1_resp_count", 32'(n_resp), 32'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the MA-stage load/store interface; the pipeline is the initiator and this block answers its requests.
- Accepts one word-sized load or store request per transaction over a valid/ready handshake.
- Returns a response after a fixed, parameterised access latency, with the response held until the initiator accepts it.
- Models a realistic multi-cycle data memory so the MA stage's stall logic can be exercised.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of 2.
- LATENCY, 2, cycles from request acceptance to resp_valid assertion; must be >= 1.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_wdata  input  32  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load data; 0 for stores.
- resp_err  output  1  address error; constant 0 unless DMEM_BOUNDS_CHECK_EN is defined.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, latency counter = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Captured request registers are cleared.
  - Memory array is not cleared.
  - Any in-flight transaction is dropped; a store that has not yet reached RESP is never written.
- req_ready is decoded from state: 1 only in IDLE, so it is 1 in the first cycle after reset release.
- FSM states IDLE, WAIT, RESP:
  - IDLE: on an edge where req_valid && req_ready, capture req_we, req_wdata and word index = req_addr[31:2] mod DEPTH. Load counter with LATENCY-1. Go to WAIT, or directly to RESP if LATENCY == 1.
  - WAIT: decrement counter each edge; on the edge where it is 0, go to RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_err are stable. On an edge with resp_ready = 1, go to IDLE and drop resp_valid.
- Latency: request accepted at edge t → resp_valid high after edge t+LATENCY.
- Memory access timing: the array is accessed on the edge entering RESP.
  - Store: writes mem[index] = wdata; resp_rdata = 0.
  - Load: resp_rdata = mem[index] as of that edge, including all previously responded stores.
- Only one outstanding transaction. req_ready = 0 in WAIT and RESP; req_valid is ignored there.
- Minimum throughput: one transaction per LATENCY+1 cycles, with resp_ready held high.
- Request signals are sampled only at acceptance; later changes have no effect.
- Backpressure: while resp_ready = 0 in RESP, all outputs hold indefinitely.
- Address wrap (no macro): the index uses the low log2(DEPTH) bits of req_addr[31:2]; higher addresses alias.
- Misaligned addresses are treated as aligned; no fault is raised.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: the full word address req_addr[31:2] is compared against DEPTH at acceptance. If it is >= DEPTH:
  - resp_err = 1 in RESP;
  - resp_rdata = 0;
  - a store performs no write;
  - latency and handshake are unchanged.
- In-range accesses give resp_err = 0.
- Not defined: resp_err is tied to 0 and out-of-range addresses wrap modulo DEPTH.

Test Plan:
- LATENCY=2: reset, store addr 0x10 data 0xDEADBEEF accepted at edge t → resp_valid high after t+2, resp_rdata 0. Then load 0x10 → resp_rdata 0xDEADBEEF.
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP while driving req_valid = 1 → resp_valid and resp_rdata constant, req_ready 0 throughout, second request not accepted until after the response handshake.
- Load 0x13 after storing 0x12345678 at 0x10 → resp_rdata 0x12345678 (low address bits ignored).
- DEPTH=1024, store 0xCAFEF00D to 0x1000, then load 0x0:
  - without macro → 0xCAFEF00D, resp_err 0;
  - with DMEM_BOUNDS_CHECK_EN → store response resp_err 1, load 0x0 returns prior value.
- Reset mid-WAIT: store 0xAAAA5555 to 0x20 over prior 0x1, assert rst_n low during WAIT → resp_valid 0 immediately; after release req_ready 1, load 0x20 returns 0x1.
- LATENCY=1, resp_ready held 1, req_valid held 1 → accepts every 2 cycles, each resp_valid one cycle after acceptance, no dropped or duplicated responses over 8 alternating store/load requests.
